spi_reg_bank: RTL and testbench

//  Parametrised SPI (mode 0) register-bank peripheral; successor of the fixed 5x8-bit write-only block.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 47 ++++
 rtl/spi_reg_bank.sv | 195 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: frame geometry, R/W encoding and FSM states.
package spi_pkg;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StCommit
    } spi_state_e;

    function automatic int unsigned frame_width(int unsigned addr_w, int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int unsigned rw_pos(int unsigned addr_w, int unsigned data_w);
        return frame_width(addr_w, data_w) - 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser with optional registered rise/fall pulses, aligned with o_q changing.
module spi_sync #(
    parameter int unsigned STAGES = 2,
    parameter bit          EDGES  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

    if (EDGES) begin : g_edges
        logic r_rise;
        logic r_fall;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= r_chain[STAGES-2] & ~r_chain[STAGES-1];
                r_fall <= ~r_chain[STAGES-2] & r_chain[STAGES-1];
            end
        end

        assign o_rise = r_rise;
        assign o_fall = r_fall;
    end else begin : g_no_edges
        assign o_rise = 1'b0;
        assign o_fall = 1'b0;
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: synchronised frame decode, register write/read-back and error pulses.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         addr_err
);

    localparam int unsigned FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int unsigned RW_POS  = rw_pos(ADDR_W, DATA_W);
    localparam int unsigned HDR_W   = 1 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ncs_sync, w_ncs_rise, w_ncs_fall;
    logic w_copi, w_copi_rise, w_copi_fall;
    logic w_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(SCLK),
        .o_q(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_d(nCS),
        .o_q(w_ncs_sync), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES + 1), .EDGES(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_d(COPI),
        .o_q(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    assign w_unused = ^{w_sclk_sync, w_copi_rise, w_copi_fall};

    spi_state_e r_state, w_state_d;
    logic [CNT_W-1:0]             r_cnt;
    logic [FRAME_W-1:0]           r_shift;
    logic [DATA_W-1:0]            r_tx;
    logic [NUM_REGS*DATA_W-1:0]   r_regs;
    logic [ADDR_W-1:0]            r_wr_addr;
    logic r_cipo, r_seen_high, r_wr_strobe, r_frame_err, r_addr_err;

    logic w_start, w_shift, w_load, w_txshift, w_commit;
    logic w_len_ok, w_addr_ok, w_rw, w_hdr_rw;
    logic [ADDR_W-1:0] w_addr, w_hdr_addr;
    logic [DATA_W-1:0] w_data, w_rd_data, w_tx_load;

    assign w_rw       = r_shift[RW_POS];
    assign w_addr     = r_shift[FRAME_W-2 -: ADDR_W];
    assign w_data     = r_shift[DATA_W-1:0];
    assign w_len_ok   = (r_cnt == CNT_W'(FRAME_W));
    assign w_addr_ok  = ({1'b0, w_addr} < NUM_REGS_A);
    // Only the header has been shifted in when the read data is fetched.
    assign w_hdr_rw   = r_shift[HDR_W-1];
    assign w_hdr_addr = r_shift[ADDR_W-1:0];

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hdr_addr == ADDR_W'(i)) w_rd_data = r_regs[i*DATA_W +: DATA_W];
        end
    end

    assign w_tx_load = (w_hdr_rw == RW_WRITE) ? '0 : w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_load    = 1'b0;
        w_txshift = 1'b0;
        w_commit  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_ncs_fall && r_seen_high) begin
                    w_state_d = StHdr;
                    w_start   = 1'b1;
                end
            end
            StHdr: begin
                if (w_ncs_rise) begin
                    w_state_d = StCommit;
                    w_commit  = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(HDR_W - 1)) w_state_d = StData;
                end
            end
            StData: begin
                if (w_ncs_rise) begin
                    w_state_d = StCommit;
                    w_commit  = 1'b1;
                end else begin
                    w_shift = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_load    = (r_cnt == CNT_W'(HDR_W));
                        w_txshift = (r_cnt != CNT_W'(HDR_W));
                    end
                end
            end
            StCommit: begin
                w_state_d = StIdle;
                if (w_ncs_fall) begin
                    w_state_d = StHdr;
                    w_start   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_regs      <= '0;
            r_wr_addr   <= '0;
            r_cipo      <= 1'b0;
            r_seen_high <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
            if (w_ncs_sync) r_seen_high <= 1'b1;
            if (w_start) begin
                r_cnt   <= '0;
                r_shift <= '0;
                r_tx    <= '0;
                r_cipo  <= 1'b0;
            end
            if (w_shift) begin
                if (r_cnt < CNT_W'(FRAME_W)) r_shift <= {r_shift[FRAME_W-2:0], w_copi};
                if (r_cnt < CNT_W'(FRAME_W + 1)) r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_cipo <= w_tx_load[DATA_W-1];
                r_tx   <= {w_tx_load[DATA_W-2:0], 1'b0};
            end else if (w_txshift) begin
                r_cipo <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_commit) begin
                r_cipo <= 1'b0;
                if (!w_len_ok) begin
                    r_frame_err <= 1'b1;
                end else if (w_rw == RW_WRITE) begin
                    if (w_addr_ok) begin
                        r_wr_strobe <= 1'b1;
                        r_wr_addr   <= w_addr;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_addr == ADDR_W'(i)) r_regs[i*DATA_W +: DATA_W] <= w_data;
                        end
                    end else begin
                        r_addr_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign CIPO      = r_cipo;
    assign cipo_oe   = r_seen_high & ~w_ncs_sync;
    assign regs_flat = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: directed SPI frames, pulse and read-back monitors.
module tb_spi_reg_bank;

    localparam int unsigned NUM_REGS    = 5;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = 8;
    localparam logic [2:0]  K_WR = 3'b100;
    localparam logic [2:0]  K_FE = 3'b010;
    localparam logic [2:0]  K_AE = 3'b001;

    logic clk, rst_n, SCLK, COPI, nCS, CIPO, cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic wr_strobe, frame_err, addr_err;
    logic [ADDR_W-1:0] wr_addr;

    spi_reg_bank #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err), .addr_err(addr_err)
    );

    typedef struct {
        logic [2:0]                 kind;
        logic [ADDR_W-1:0]          addr;
        logic [NUM_REGS*DATA_W-1:0] regs;
    } pulse_t;

    pulse_t                pulse_q[$];
    logic [DATA_W-1:0]     rd_q[$];
    logic [NUM_REGS*DATA_W-1:0] model;
    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_pulse(input logic [2:0] kind, input logic [ADDR_W-1:0] addr);
        pulse_t e;
        e.kind = kind;
        e.addr = addr;
        e.regs = model;
        pulse_q.push_back(e);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n, input bit raise, input int gap);
        nCS = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            COPI = val[i];
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        COPI = 1'b0;
        repeat (HALF) @(negedge clk);
        if (raise) begin
            nCS = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Pulse monitor: every strobe/error pulse must match the head of the expectation queue.
    initial begin
        pulse_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (wr_strobe || frame_err || addr_err)) begin
                if (pulse_q.size() == 0) begin
                    check("unexpected_pulse", {61'd0, wr_strobe, frame_err, addr_err}, 64'd0);
                end else begin
                    e = pulse_q.pop_front();
                    check("pulse_kind", {61'd0, wr_strobe, frame_err, addr_err}, {61'd0, e.kind});
                    check("pulse_latency", 64'(cyc - rise_cyc), 64'(SYNC_STAGES + 1));
                    check("regs_flat", 64'(regs_flat), 64'(e.regs));
                    if (e.kind == K_WR) check("wr_addr", 64'(wr_addr), 64'(e.addr));
                end
            end
        end
    end

    // Read-back monitor: samples CIPO at the pin SCLK rising edges, like a controller would.
    initial begin
        logic p_sclk, p_ncs;
        logic [31:0] rx, tx;
        int bcnt;
        p_sclk = 1'b0;
        p_ncs  = 1'b1;
        rx = '0;
        tx = '0;
        bcnt = 0;
        forever begin
            @(SCLK or nCS);
            if (nCS !== p_ncs) begin
                if (nCS === 1'b0) begin
                    bcnt = 0;
                end else begin
                    rise_cyc = cyc;
                    if (bcnt == 16 && tx[15] == 1'b0) begin
                        if (rd_q.size() == 0) check("unexpected_read", 64'(rx[7:0]), 64'd0);
                        else check("cipo_data", 64'(rx[7:0]), 64'(rd_q.pop_front()));
                    end
                end
            end else if (SCLK === 1'b1 && p_sclk === 1'b0 && nCS === 1'b0) begin
                rx = {rx[30:0], CIPO};
                tx = {tx[30:0], COPI};
                bcnt++;
                if (rst_n) check("cipo_oe_in_frame", 64'(cipo_oe), 64'd1);
            end
            p_sclk = SCLK;
            p_ncs  = nCS;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regs"},  64'(regs_flat), 64'd0);
        check({tag, "_waddr"}, 64'(wr_addr),   64'd0);
        check({tag, "_strb"},  64'(wr_strobe), 64'd0);
        check({tag, "_ferr"},  64'(frame_err), 64'd0);
        check({tag, "_aerr"},  64'(addr_err),  64'd0);
        check({tag, "_cipo"},  64'(CIPO),      64'd0);
        check({tag, "_oe"},    64'(cipo_oe),   64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        SCLK  = 1'b0;
        COPI  = 1'b0;
        nCS   = 1'b1;
        model = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Plain write to reg 0.
        model[7:0] = 8'hA5;
        push_pulse(K_WR, 7'd0);
        spi_bits(32'h80A5, 16, 1'b1, 20);

        // Write reg 2 then read it back; the read produces no pulse.
        model[23:16] = 8'h3C;
        push_pulse(K_WR, 7'd2);
        spi_bits(32'h823C, 16, 1'b1, 20);
        rd_q.push_back(8'h3C);
        spi_bits(32'h0200, 16, 1'b1, 20);

        // Out-of-range address: write rejected, read returns zeros.
        push_pulse(K_AE, 7'd0);
        spi_bits(32'h8511, 16, 1'b1, 20);
        rd_q.push_back(8'h00);
        spi_bits(32'h0500, 16, 1'b1, 20);

        // Short and long frames.
        push_pulse(K_FE, 7'd0);
        spi_bits(32'h080A, 12, 1'b1, 20);
        push_pulse(K_FE, 7'd0);
        spi_bits(32'h1_0155, 17, 1'b1, 20);

        // Reset after the first 9 bits of 0x84FF, with nCS still low.
        spi_bits(32'h0109, 9, 1'b0, 0);
        rst_n = 1'b0;
        model = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_oe_ncs_low", 64'(cipo_oe), 64'd0);
        nCS = 1'b1;
        repeat (10) @(negedge clk);
        model[39:32] = 8'h77;
        push_pulse(K_WR, 7'd4);
        spi_bits(32'h8477, 16, 1'b1, 20);

        // Back-to-back writes with the minimum nCS-high gap.
        model[7:0] = 8'h01;
        push_pulse(K_WR, 7'd0);
        spi_bits(32'h8001, 16, 1'b1, SYNC_STAGES + 2);
        model[15:8] = 8'h02;
        push_pulse(K_WR, 7'd1);
        spi_bits(32'h8102, 16, 1'b1, 20);

        repeat (20) @(negedge clk);
        check("pulses_outstanding", 64'(pulse_q.size()), 64'd0);
        check("reads_outstanding", 64'(rd_q.size()), 64'd0);
        check("final_regs", 64'(regs_flat), 64'h77_00_00_02_01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
